// File: rtl/mips_mem_if_pkg.sv
// ============================================================================
//  Module      : mips_mem_if_pkg
//  Description : Shared types and fault codes for the MIPS memory interface.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package mips_mem_if_pkg;

    typedef enum logic [1:0] {
        MEM_FAULT_NONE    = 2'b00,
        MEM_FAULT_ALIGN   = 2'b01,
        MEM_FAULT_RANGE   = 2'b10,
        MEM_FAULT_IRPROTO = 2'b11
    } fault_code_t;

    typedef struct packed {
        logic valid;
        logic tag;
        logic bad;
    } rd_entry_t;

    // Misalignment outranks out-of-range when both apply.
    function automatic fault_code_t classify_access(input logic misaligned,
                                                    input logic out_of_range);
        fault_code_t code;
        code = MEM_FAULT_NONE;
        if (misaligned)
            code = MEM_FAULT_ALIGN;
        else if (out_of_range)
            code = MEM_FAULT_RANGE;
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_mem_if_if.sv
// ============================================================================
//  Module      : mips_mem_if_if
//  Description : Datapath/RAM-side bus bundle of the MIPS memory interface.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface mips_mem_if_if #(
    parameter int ADDR_W = 10
) ();

    logic [31:0]       pc;
    logic [31:0]       alu_out;
    logic              IorD;
    logic              MemWrite;
    logic              IRWrite;
    logic [31:0]       wr_data;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic [31:0]       instr;
    logic [31:0]       mem_data;
    logic              rd_valid;
    logic              fault;
    logic [1:0]        fault_code;

    modport master (
        output pc, alu_out, IorD, MemWrite, IRWrite, wr_data, ram_rdata,
        input  ram_addr, ram_we, ram_wdata, instr, mem_data, rd_valid,
               fault, fault_code
    );

    modport slave (
        input  pc, alu_out, IorD, MemWrite, IRWrite, wr_data, ram_rdata,
        output ram_addr, ram_we, ram_wdata, instr, mem_data, rd_valid,
               fault, fault_code
    );

endinterface

`default_nettype wire

// File: rtl/mips_rd_pipe.sv
// ============================================================================
//  Module      : mips_rd_pipe
//  Description : DEPTH-stage shift register of {valid, tag, bad} read entries.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module mips_rd_pipe
    import mips_mem_if_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  wire logic      clk,
    input  wire logic      rst,
    input  rd_entry_t      push,
    output rd_entry_t      head
);

    logic [3*DEPTH-1:0] r_shift;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (!rst)
                    r_shift <= '0;
                else
                    r_shift <= push;
            end
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (!rst)
                    r_shift <= '0;
                else
                    r_shift <= {r_shift[3*DEPTH-4:0], push};
            end
        end
    endgenerate

    assign head = r_shift[3*DEPTH-1 -: 3];

endmodule

`default_nettype wire

// File: rtl/mips_mem_if.sv
// ============================================================================
//  Module      : mips_mem_if
//  Description : Multicycle MIPS memory interface: address select, write
//                gating, tagged read tracking, IR/MDR and sticky fault report.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module mips_mem_if
    import mips_mem_if_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mips_mem_if_if.slave  bus
);

    logic [31:0] w_byte_addr;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic        w_access_fault;
    fault_code_t w_access_code;
    rd_entry_t   w_push;
    rd_entry_t   w_head;
    logic [31:0] w_ret_word;
    logic        w_mdr_load;
    logic        w_ir_load;
    logic        w_proto_fault;

    logic [31:0] r_instr;
    logic [31:0] r_mdr;
    logic        r_fault;
    fault_code_t r_fault_code;

    assign w_byte_addr    = bus.IorD ? bus.alu_out : bus.pc;
    assign w_misaligned   = |w_byte_addr[1:0];
    assign w_out_of_range = |w_byte_addr[31:ADDR_W+2];
    assign w_access_fault = w_misaligned | w_out_of_range;
    assign w_access_code  = classify_access(w_misaligned, w_out_of_range);

    assign bus.ram_addr  = w_byte_addr[ADDR_W+1:2];
    assign bus.ram_wdata = bus.wr_data;
    assign bus.ram_we    = rst & bus.MemWrite & ~w_access_fault;

    // Write cycles occupy a pipeline slot as an invalid entry.
    assign w_push = '{valid: ~bus.MemWrite, tag: bus.IorD, bad: w_access_fault};

    mips_rd_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_pipe (
        .clk  (clk),
        .rst  (rst),
        .push (w_push),
        .head (w_head)
    );

    assign w_ret_word    = w_head.bad ? 32'h0 : bus.ram_rdata;
    assign w_mdr_load    = w_head.valid & w_head.tag;
    assign w_ir_load     = bus.IRWrite & w_head.valid & ~w_head.tag;
    assign w_proto_fault = bus.IRWrite & ~(w_head.valid & ~w_head.tag);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_instr      <= '0;
            r_mdr        <= '0;
            r_fault      <= 1'b0;
            r_fault_code <= MEM_FAULT_NONE;
        end else begin
            if (w_mdr_load)
                r_mdr <= w_ret_word;
            if (w_ir_load)
                r_instr <= w_ret_word;
            // Only the first fault is recorded; access faults beat protocol.
            if (!r_fault) begin
                if (w_access_fault) begin
                    r_fault      <= 1'b1;
                    r_fault_code <= w_access_code;
                end else if (w_proto_fault) begin
                    r_fault      <= 1'b1;
                    r_fault_code <= MEM_FAULT_IRPROTO;
                end
            end
        end
    end

    assign bus.instr      = r_instr;
    assign bus.mem_data   = r_mdr;
    assign bus.rd_valid   = w_head.valid;
    assign bus.fault      = r_fault;
    assign bus.fault_code = r_fault_code;

endmodule

`default_nettype wire

// File: tb/tb_mips_mem_if.sv
// ============================================================================
//  Module      : tb_mips_mem_if
//  Description : Self-checking bench for mips_mem_if with a RAM model and a
//                read-return scoreboard.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mips_mem_if;

    localparam int ADDR_W = 10;
    localparam int RD_LAT = 1;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mips_mem_if_if #(.ADDR_W(ADDR_W)) bus ();

    mips_mem_if #(
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] ram     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] ram_q;

    always @(posedge clk) begin
        if (bus.ram_we)
            ram[bus.ram_addr] <= bus.ram_wdata;
        ram_q <= ram[bus.ram_addr];
    end
    assign bus.ram_rdata = ram_q;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        valid;
        logic        tag;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_ir, m_mdr;
    logic        m_fault;
    logic [1:0]  m_code;
    bit          mon_en = 1'b0;

    function automatic logic [31:0] pattern(input int i);
        logic [31:0] w;
        w = {16'h5A5A, 16'(i)};
        if (i == 2)    w = 32'h2002_0005;
        if (i == 4)    w = 32'hDEAD_BEEF;
        if (i == 1023) w = 32'hA5A5_0FFC;
        return w;
    endfunction

    // Scoreboard: expected return entries are queued when each read is issued.
    always @(negedge clk) begin : mon
        exp_t        h, p;
        logic [31:0] ba, ret;
        logic        mis, oor, we_exp, proto;
        h      = q.pop_front();
        ba     = bus.IorD ? bus.alu_out : bus.pc;
        mis    = (ba[1:0] != 2'b00);
        oor    = (ba[31:ADDR_W+2] != '0);
        we_exp = rst & bus.MemWrite & ~(mis | oor);
        if (mon_en) begin
            total++;
            if (bus.rd_valid !== h.valid) begin
                bad++;
                $display("FAIL sb_rd_valid t=%0t got=%b want=%b", $time, bus.rd_valid, h.valid);
            end
            total++;
            if (bus.mem_data !== m_mdr) begin
                bad++;
                $display("FAIL sb_mem_data t=%0t got=%h want=%h", $time, bus.mem_data, m_mdr);
            end
            total++;
            if (bus.instr !== m_ir) begin
                bad++;
                $display("FAIL sb_instr t=%0t got=%h want=%h", $time, bus.instr, m_ir);
            end
            total++;
            if ({bus.fault, bus.fault_code} !== {m_fault, m_code}) begin
                bad++;
                $display("FAIL sb_fault t=%0t got=%b/%b want=%b/%b", $time, bus.fault, bus.fault_code, m_fault, m_code);
            end
            total++;
            if (bus.ram_we !== we_exp || bus.ram_addr !== ba[ADDR_W+1:2]) begin
                bad++;
                $display("FAIL sb_ram_port t=%0t got we=%b addr=%h want we=%b addr=%h", $time, bus.ram_we, bus.ram_addr, we_exp, ba[ADDR_W+1:2]);
            end
        end
        if (!rst) begin
            m_ir = '0; m_mdr = '0; m_fault = 1'b0; m_code = 2'b00;
            q.delete();
            for (int i = 0; i < RD_LAT; i++) q.push_back('{1'b0, 1'b0, 1'b0, 32'h0});
        end else begin
            ret   = h.err ? 32'h0 : h.data;
            proto = bus.IRWrite & ~(h.valid & ~h.tag);
            if (h.valid && h.tag) m_mdr = ret;
            if (bus.IRWrite && h.valid && !h.tag) m_ir = ret;
            if (!m_fault) begin
                if (mis)        begin m_fault = 1'b1; m_code = 2'b01; end
                else if (oor)   begin m_fault = 1'b1; m_code = 2'b10; end
                else if (proto) begin m_fault = 1'b1; m_code = 2'b11; end
            end
            p.valid = ~bus.MemWrite;
            p.tag   = bus.IorD;
            p.err   = mis | oor;
            p.data  = ref_mem[ba[ADDR_W+1:2]];
            q.push_back(p);
            if (we_exp) ref_mem[ba[ADDR_W+1:2]] = bus.wr_data;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pc = 32'h0; bus.alu_out = 32'h0; bus.IorD = 1'b0;
        bus.MemWrite = 1'b0; bus.IRWrite = 1'b0; bus.wr_data = 32'h0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        total++; if (bus.instr !== 32'h0)      begin bad++; $display("FAIL reset_instr got=%h want=0", bus.instr); end
        total++; if (bus.mem_data !== 32'h0)   begin bad++; $display("FAIL reset_mem_data got=%h want=0", bus.mem_data); end
        total++; if (bus.rd_valid !== 1'b0)    begin bad++; $display("FAIL reset_rd_valid got=%b want=0", bus.rd_valid); end
        total++; if (bus.fault !== 1'b0)       begin bad++; $display("FAIL reset_fault got=%b want=0", bus.fault); end
        total++; if (bus.fault_code !== 2'b00) begin bad++; $display("FAIL reset_code got=%b want=00", bus.fault_code); end
        cyc();
    endtask

    task automatic test_fetch();
        bus.pc = 32'h8; bus.IorD = 1'b0;
        cyc();
        bus.pc = 32'h0; bus.IRWrite = 1'b1;
        @(negedge clk);
        total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL fetch_rd_valid got=%b want=1", bus.rd_valid); end
        cyc();
        bus.IRWrite = 1'b0;
        @(negedge clk);
        total++; if (bus.instr !== 32'h2002_0005) begin bad++; $display("FAIL fetch_instr got=%h want=20020005", bus.instr); end
        total++; if (bus.mem_data !== 32'h0)      begin bad++; $display("FAIL fetch_mem_data got=%h want=0", bus.mem_data); end
        total++; if (bus.fault !== 1'b0)          begin bad++; $display("FAIL fetch_fault got=%b want=0", bus.fault); end
        cyc();
    endtask

    task automatic test_load();
        bus.IorD = 1'b1; bus.alu_out = 32'h10;
        cyc();
        @(negedge clk);
        total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL load_rd_valid got=%b want=1", bus.rd_valid); end
        cyc();
        idle();
        @(negedge clk);
        total++; if (bus.mem_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_mem_data got=%h want=deadbeef", bus.mem_data); end
        total++; if (bus.instr !== 32'h2002_0005)    begin bad++; $display("FAIL load_instr got=%h want=20020005", bus.instr); end
        cyc();
    endtask

    task automatic test_store();
        bus.IorD = 1'b1; bus.alu_out = 32'h0C; bus.wr_data = 32'h1234_5678; bus.MemWrite = 1'b1;
        @(negedge clk);
        total++; if (bus.ram_we !== 1'b1)             begin bad++; $display("FAIL store_we got=%b want=1", bus.ram_we); end
        total++; if (bus.ram_addr !== 10'd3)          begin bad++; $display("FAIL store_addr got=%h want=3", bus.ram_addr); end
        total++; if (bus.ram_wdata !== 32'h1234_5678) begin bad++; $display("FAIL store_wdata got=%h want=12345678", bus.ram_wdata); end
        cyc();
        bus.MemWrite = 1'b0;
        cyc();
        idle();
        cyc();
        @(negedge clk);
        total++; if (bus.mem_data !== 32'h1234_5678) begin bad++; $display("FAIL store_readback got=%h want=12345678", bus.mem_data); end
        bus.IorD = 1'b1; bus.alu_out = 32'h0E; bus.wr_data = 32'hFFFF_0000; bus.MemWrite = 1'b1;
        #1;
        total++; if (bus.ram_we !== 1'b0) begin bad++; $display("FAIL misalign_we got=%b want=0", bus.ram_we); end
        cyc();
        idle();
        @(negedge clk);
        total++; if ({bus.fault, bus.fault_code} !== 3'b101) begin bad++; $display("FAIL misalign_fault got=%b/%b want=1/01", bus.fault, bus.fault_code); end
        bus.IorD = 1'b1; bus.alu_out = 32'h1000; bus.MemWrite = 1'b1;
        #1;
        total++; if (bus.ram_we !== 1'b0) begin bad++; $display("FAIL range_store_we got=%b want=0", bus.ram_we); end
        cyc();
        idle();
        @(negedge clk);
        total++; if (bus.fault_code !== 2'b01) begin bad++; $display("FAIL sticky_code got=%b want=01", bus.fault_code); end
        cyc();
    endtask

    task automatic test_boundary();
        do_reset();
        bus.IorD = 1'b1; bus.alu_out = 32'h10;
        cyc();
        bus.alu_out = 32'hFFC;
        cyc();
        bus.alu_out = 32'h1000;
        @(negedge clk);
        total++; if (bus.mem_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bound_pre_load got=%h want=deadbeef", bus.mem_data); end
        total++; if (bus.fault !== 1'b0)             begin bad++; $display("FAIL bound_top_legal got=%b want=0", bus.fault); end
        total++; if (bus.ram_we !== 1'b0)            begin bad++; $display("FAIL bound_oor_we got=%b want=0", bus.ram_we); end
        cyc();
        idle();
        @(negedge clk);
        total++; if (bus.mem_data !== 32'hA5A5_0FFC) begin bad++; $display("FAIL bound_top_data got=%h want=a5a50ffc", bus.mem_data); end
        total++; if ({bus.fault, bus.fault_code} !== 3'b110) begin bad++; $display("FAIL bound_range_code got=%b/%b want=1/10", bus.fault, bus.fault_code); end
        cyc();
        @(negedge clk);
        total++; if (bus.mem_data !== 32'h0) begin bad++; $display("FAIL bound_oor_data got=%h want=0", bus.mem_data); end
        cyc();
    endtask

    task automatic test_ir_proto();
        do_reset();
        bus.IRWrite = 1'b1;
        @(negedge clk);
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL proto_rd_valid got=%b want=0", bus.rd_valid); end
        cyc();
        bus.IRWrite = 1'b0;
        @(negedge clk);
        total++; if (bus.instr !== 32'h0) begin bad++; $display("FAIL proto_instr got=%h want=0", bus.instr); end
        total++; if ({bus.fault, bus.fault_code} !== 3'b111) begin bad++; $display("FAIL proto_code got=%b/%b want=1/11", bus.fault, bus.fault_code); end
        cyc();
    endtask

    task automatic test_back_to_back();
        bus.IorD = 1'b1; bus.alu_out = 32'h20;
        cyc();
        bus.alu_out = 32'h24;
        @(negedge clk);
        total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL b2b_rd_valid got=%b want=1", bus.rd_valid); end
        cyc();
        bus.MemWrite = 1'b1; bus.wr_data = 32'hCAFE_0001;
        @(negedge clk);
        total++; if (bus.mem_data !== 32'h5A5A_0008) begin bad++; $display("FAIL b2b_first got=%h want=5a5a0008", bus.mem_data); end
        cyc();
        bus.MemWrite = 1'b0;
        @(negedge clk);
        total++; if (bus.mem_data !== 32'h5A5A_0009) begin bad++; $display("FAIL b2b_rd_before_wr got=%h want=5a5a0009", bus.mem_data); end
        total++; if (bus.rd_valid !== 1'b0)          begin bad++; $display("FAIL b2b_wr_slot got=%b want=0", bus.rd_valid); end
        cyc();
        idle();
        cyc();
        @(negedge clk);
        total++; if (bus.mem_data !== 32'hCAFE_0001) begin bad++; $display("FAIL b2b_after_wr got=%h want=cafe0001", bus.mem_data); end
        cyc();
    endtask

    task automatic test_reset_mid_write();
        bus.pc = 32'h8;
        cyc();
        bus.pc = 32'h0; bus.IRWrite = 1'b1;
        cyc();
        bus.IorD = 1'b1; bus.alu_out = 32'h30; bus.wr_data = 32'h0000_0BAD;
        bus.MemWrite = 1'b1; bus.IRWrite = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.instr !== 32'h2002_0005) begin bad++; $display("FAIL rstw_pre_instr got=%h want=20020005", bus.instr); end
        total++; if (bus.ram_we !== 1'b0)         begin bad++; $display("FAIL rstw_we got=%b want=0", bus.ram_we); end
        total++; if (bus.ram_addr !== 10'd12)     begin bad++; $display("FAIL rstw_addr got=%h want=00c", bus.ram_addr); end
        cyc();
        rst = 1'b1;
        idle();
        @(negedge clk);
        total++; if ({bus.instr, bus.mem_data} !== 64'h0) begin bad++; $display("FAIL rstw_regs got=%h/%h want=0/0", bus.instr, bus.mem_data); end
        total++; if ({bus.rd_valid, bus.fault, bus.fault_code} !== 4'b0000) begin bad++; $display("FAIL rstw_flags got=%b%b%b want=0000", bus.rd_valid, bus.fault, bus.fault_code); end
        cyc();
        bus.IorD = 1'b1; bus.alu_out = 32'h30;
        cyc();
        idle();
        cyc();
        @(negedge clk);
        total++; if (bus.mem_data !== 32'h5A5A_000C) begin bad++; $display("FAIL rstw_no_write got=%h want=5a5a000c", bus.mem_data); end
        cyc();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = pattern(i);
            ref_mem[i] = pattern(i);
        end
        for (int i = 0; i < RD_LAT; i++) q.push_back('{1'b0, 1'b0, 1'b0, 32'h0});
        idle();
        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_boundary();
        test_ir_proto();
        test_back_to_back();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
